// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared constants, state encodings and helpers for the MDIO PHY sequencer.
package mdio_pkg;

   localparam logic [4:0] REG_BMCR  = 5'd0;
   localparam logic [4:0] REG_BMSR  = 5'd1;
   localparam logic [4:0] REG_PHYSR = 5'd17;

   localparam int BMCR_RST     = 15;
   localparam int BMSR_LNK     = 2;
   localparam int PHYSR_SPD_HI = 15;
   localparam int PHYSR_DUP    = 13;
   localparam int PHYSR_LNK    = 10;

   localparam logic [1:0] SPD_10   = 2'b00;
   localparam logic [1:0] SPD_100  = 2'b01;
   localparam logic [1:0] SPD_1000 = 2'b10;

   typedef enum logic [6:0] {
      ST_IDLE     = 7'b000_0001,
      ST_RST_WR   = 7'b000_0010,
      ST_RST_RD   = 7'b000_0100,
      ST_RD_BMSR  = 7'b000_1000,
      ST_RD_PHYSR = 7'b001_0000,
      ST_UPDATE   = 7'b010_0000,
      ST_WAIT     = 7'b100_0000
   } state_e;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'd0,
      PH_ISSUE = 2'd1,
      PH_PEND  = 2'd2
   } phase_e;

   // The reserved speed code 11 is reported as 10M.
   function automatic logic [1:0] map_speed(input logic [1:0] raw);
      return (raw == 2'b11) ? SPD_10 : raw;
   endfunction

endpackage

// File: rtl/mdio_phy_ctrl_if.sv
// rtl/mdio_phy_ctrl_if.sv - op_* handshake between the sequencer and the MDIO driver.
interface mdio_phy_ctrl_if;

   logic        op_exec;
   logic        op_rh_wl;
   logic [4:0]  op_addr;
   logic [15:0] op_wr_data;
   logic        op_done;
   logic [15:0] op_rd_data;
   logic        op_rd_ack;

   modport master (
      output op_exec, op_rh_wl, op_addr, op_wr_data,
      input  op_done, op_rd_data, op_rd_ack
   );

   modport slave (
      input  op_exec, op_rh_wl, op_addr, op_wr_data,
      output op_done, op_rd_data, op_rd_ack
   );

endinterface

// File: rtl/mdio_txn_seq.sv
// rtl/mdio_txn_seq.sv - one driver transaction: ISSUE pulse, PEND wait, saturating timeout.
module mdio_txn_seq import mdio_pkg::*; #(
   parameter logic [15:0] OP_TIMEOUT = 16'd1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic        rh_wl_i,
   input  logic [4:0]  addr_i,
   input  logic [15:0] wr_data_i,
   output logic        idle_o,
   output logic        done_o,
   output logic        nack_o,
   output logic        timeout_o,
   output logic [15:0] rd_data_o,
   mdio_phy_ctrl_if.master op
);

   phase_e      phase_q, phase_d;
   logic [15:0] tmo_q, tmo_d;
   logic        rh_wl_q, rh_wl_d;
   logic [4:0]  addr_q, addr_d;
   logic [15:0] wr_data_q, wr_data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q   <= PH_IDLE;
         tmo_q     <= '0;
         rh_wl_q   <= 1'b1;
         addr_q    <= '0;
         wr_data_q <= '0;
      end else begin
         phase_q   <= phase_d;
         tmo_q     <= tmo_d;
         rh_wl_q   <= rh_wl_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // op_done is only looked at in PEND, so a stray pulse outside a transaction is dropped.
   always_comb begin
      phase_d   = phase_q;
      tmo_d     = tmo_q;
      rh_wl_d   = rh_wl_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      done_o    = 1'b0;
      timeout_o = 1'b0;
      case (phase_q)
         PH_IDLE: begin
            if (start_i) begin
               phase_d   = PH_ISSUE;
               rh_wl_d   = rh_wl_i;
               addr_d    = addr_i;
               wr_data_d = wr_data_i;
            end
         end
         PH_ISSUE: begin
            phase_d = PH_PEND;
            tmo_d   = '0;
         end
         PH_PEND: begin
            if (op.op_done) begin
               done_o  = 1'b1;
               phase_d = PH_IDLE;
            end else if (tmo_q == OP_TIMEOUT) begin
               timeout_o = 1'b1;
               phase_d   = PH_IDLE;
            end else if (tmo_q != 16'hFFFF) begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         default: phase_d = PH_IDLE;
      endcase
   end

   assign op.op_exec    = (phase_q == PH_ISSUE);
   assign op.op_rh_wl   = rh_wl_q;
   assign op.op_addr    = addr_q;
   assign op.op_wr_data = wr_data_q;

   assign idle_o    = (phase_q == PH_IDLE);
   assign nack_o    = op.op_rd_ack;
   assign rd_data_o = op.op_rd_data;

endmodule

// File: rtl/mdio_phy_ctrl.sv
// rtl/mdio_phy_ctrl.sv - PHY soft reset, reset-clear polling and periodic link/speed status polling.
module mdio_phy_ctrl import mdio_pkg::*; #(
   parameter logic [15:0] PHY_RST_DATA = 16'h9140,
   parameter logic [23:0] POLL_CYCLES  = 24'd250000,
   parameter logic [15:0] OP_TIMEOUT   = 16'd1023,
   parameter logic [7:0]  RST_POLL_MAX = 8'd100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       soft_rst_req,
   mdio_phy_ctrl_if.master op,
   output logic       link_up,
   output logic [1:0] speed,
   output logic       duplex,
   output logic       link_chg,
   output logic       phy_err,
   output logic       busy
);

   state_e      state_q, state_d;
   logic [7:0]  retry_q, retry_d;
   logic [23:0] wait_q, wait_d;
   logic        srst_q, srst_d;
   logic        err_q, err_d;
   logic        link_q, link_d;
   logic [1:0]  speed_q, speed_d;
   logic        dup_q, dup_d;
   logic        chg_q, chg_d;
   logic        nlink_q, nlink_d;
   logic [1:0]  nspeed_q, nspeed_d;
   logic        ndup_q, ndup_d;

   logic        txn_start, txn_rh_wl, txn_idle, txn_done, txn_nack, txn_tmo;
   logic [4:0]  txn_addr;
   logic [15:0] txn_rd_data;

   mdio_txn_seq #(.OP_TIMEOUT(OP_TIMEOUT)) u_txn (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (txn_start),
      .rh_wl_i   (txn_rh_wl),
      .addr_i    (txn_addr),
      .wr_data_i (PHY_RST_DATA),
      .idle_o    (txn_idle),
      .done_o    (txn_done),
      .nack_o    (txn_nack),
      .timeout_o (txn_tmo),
      .rd_data_o (txn_rd_data),
      .op        (op)
   );

   always_comb begin
      txn_rh_wl = 1'b1;
      txn_addr  = REG_BMCR;
      case (state_q)
         ST_RST_WR:   txn_rh_wl = 1'b0;
         ST_RD_BMSR:  txn_addr  = REG_BMSR;
         ST_RD_PHYSR: txn_addr  = REG_PHYSR;
         default: ;
      endcase
   end

   // A new transaction starts once the sequencer has returned to idle, one cycle after op_done.
   assign txn_start = txn_idle &&
                      (state_q inside {ST_RST_WR, ST_RST_RD, ST_RD_BMSR, ST_RD_PHYSR});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         retry_q  <= '0;
         wait_q   <= '0;
         srst_q   <= 1'b0;
         err_q    <= 1'b0;
         link_q   <= 1'b0;
         speed_q  <= SPD_10;
         dup_q    <= 1'b0;
         chg_q    <= 1'b0;
         nlink_q  <= 1'b0;
         nspeed_q <= SPD_10;
         ndup_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         retry_q  <= retry_d;
         wait_q   <= wait_d;
         srst_q   <= srst_d;
         err_q    <= err_d;
         link_q   <= link_d;
         speed_q  <= speed_d;
         dup_q    <= dup_d;
         chg_q    <= chg_d;
         nlink_q  <= nlink_d;
         nspeed_q <= nspeed_d;
         ndup_q   <= ndup_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      retry_d  = retry_q;
      wait_d   = '0;
      srst_d   = srst_q | soft_rst_req;
      err_d    = err_q;
      link_d   = link_q;
      speed_d  = speed_q;
      dup_d    = dup_q;
      chg_d    = 1'b0;
      nlink_d  = nlink_q;
      nspeed_d = nspeed_q;
      ndup_d   = ndup_q;
      if (txn_tmo) begin
         err_d   = 1'b1;
         state_d = ST_WAIT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               retry_d = '0;
               state_d = ST_RST_WR;
            end
            ST_RST_WR: begin
               if (txn_done) state_d = ST_RST_RD;
            end
            ST_RST_RD: begin
               if (txn_done) begin
                  if (txn_nack) begin
                     err_d   = 1'b1;
                     state_d = ST_WAIT;
                  end else if (!txn_rd_data[BMCR_RST]) begin
                     state_d = ST_RD_BMSR;
                  end else begin
                     retry_d = retry_q + 8'd1;
                     if (retry_d == RST_POLL_MAX) begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT;
                     end
                  end
               end
            end
            ST_RD_BMSR: begin
               if (txn_done) begin
                  if (txn_nack) begin
                     err_d   = 1'b1;
                     state_d = ST_WAIT;
                  end else if (!txn_rd_data[BMSR_LNK]) begin
                     nlink_d  = 1'b0;
                     nspeed_d = SPD_10;
                     ndup_d   = 1'b0;
                     state_d  = ST_UPDATE;
                  end else begin
                     state_d = ST_RD_PHYSR;
                  end
               end
            end
            ST_RD_PHYSR: begin
               if (txn_done) begin
                  if (txn_nack) begin
                     err_d   = 1'b1;
                     state_d = ST_WAIT;
                  end else begin
                     nspeed_d = map_speed(txn_rd_data[PHYSR_SPD_HI -: 2]);
                     ndup_d   = txn_rd_data[PHYSR_DUP];
                     nlink_d  = txn_rd_data[PHYSR_LNK];
                     state_d  = ST_UPDATE;
                  end
               end
            end
            ST_UPDATE: begin
               link_d  = nlink_q;
               speed_d = nspeed_q;
               dup_d   = ndup_q;
               chg_d   = (nlink_q != link_q) || (nspeed_q != speed_q) || (ndup_q != dup_q);
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               // A pending re-init request wins over the poll timer.
               if (srst_q) begin
                  srst_d  = soft_rst_req;
                  err_d   = 1'b0;
                  link_d  = 1'b0;
                  speed_d = SPD_10;
                  dup_d   = 1'b0;
                  chg_d   = link_q || (speed_q != SPD_10) || dup_q;
                  retry_d = '0;
                  state_d = ST_RST_WR;
               end else if (wait_q == POLL_CYCLES - 24'd1) begin
                  state_d = ST_RD_BMSR;
               end else begin
                  wait_d = wait_q + 24'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign link_up  = link_q;
   assign speed    = speed_q;
   assign duplex   = dup_q;
   assign link_chg = chg_q;
   assign phy_err  = err_q;
   assign busy     = !(state_q inside {ST_IDLE, ST_WAIT});

endmodule
